// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the two-requester memory arbiter:
//   arb_state_e : transaction FSM states (IDLE / REQ / RESP / DRAIN)
//   req_id_e    : requester identity (REQ_I = instruction, REQ_D = data)
//   TIMEOUT_DEFAULT : default RESP-state wait budget in cycles
//   cnt_width() : width of the RESP wait counter for a given timeout
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } arb_state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

  localparam int TIMEOUT_DEFAULT = 16;

  // The counter only has to hold 0 .. TIMEOUT-1; never narrower than 1 bit.
  function automatic int cnt_width(input int timeout);
    if (timeout < 2) begin
      return 1;
    end else begin
      return $clog2(timeout);
    end
  endfunction

endpackage : mem_arb_pkg

// File: rtl/mem_arb_grant.sv
// ---------------------------------------------------------------------------
// mem_arb_grant
// Combinational tie-break for the arbiter.
// Ports:
//   i_valid    in  instruction requester valid
//   d_valid    in  data requester valid
//   last_grant in  requester that won the previous accept
//   winner     out requester granted this cycle (meaningful only when
//                  at least one valid is high)
// A lone requester always wins; on a tie the requester that did not win
// last time is chosen.
// ---------------------------------------------------------------------------
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic    i_valid,
  input  logic    d_valid,
  input  req_id_e last_grant,
  output req_id_e winner
);

  // Pick the winner from the two valids and the previous grant.
  always_comb begin
    winner = REQ_D;
    if (i_valid && d_valid) begin
      winner = (last_grant == REQ_I) ? REQ_D : REQ_I;
    end else if (i_valid) begin
      winner = REQ_I;
    end else begin
      winner = REQ_D;
    end
  end

endmodule : mem_arb_grant

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Arbitrates an instruction-fetch port and a data port onto one memory port,
// with at most one transaction outstanding and a response timeout.
//
// Parameters:
//   ADDR_W  : address width of every port (data is fixed at 32 bits)
//   TIMEOUT : RESP-state cycles to wait before answering with an error (>= 1)
//
// Ports:
//   clk, reset                    clock; asynchronous active-low reset
//   i_req_valid/ready/addr        instruction read request
//   i_rsp_valid                   instruction response strobe
//   d_req_valid/ready/addr/wstrb/wdata  data request (wstrb==0 means read)
//   d_rsp_valid                   data response strobe
//   rsp_rdata, rsp_err            shared response payload, zero when idle
//   m_req_valid/ready/addr/wstrb/wdata  memory request (fields zero when idle)
//   m_rsp_valid, m_rsp_rdata      single-cycle memory response
//
// Build option:
//   ARB_ROUND_ROBIN_EN  when defined, ties alternate between requesters
//                       (first tie after reset goes to I); otherwise every
//                       tie goes to D.
// ---------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_rsp_valid,

  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [3:0]        d_req_wstrb,
  input  logic [31:0]       d_req_wdata,
  output logic              d_rsp_valid,

  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,

  output logic              m_req_valid,
  input  logic              m_req_ready,
  output logic [ADDR_W-1:0] m_req_addr,
  output logic [3:0]        m_req_wstrb,
  output logic [31:0]       m_req_wdata,
  input  logic              m_rsp_valid,
  input  logic [31:0]       m_rsp_rdata
);

  localparam int               CNT_W    = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  req_id_e           owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       wdata_q, wdata_d;

  req_id_e           last_grant_s;
  req_id_e           winner_s;
  logic              any_valid_s;
  logic              accept_s;
  logic              timeout_s;

`ifdef ARB_ROUND_ROBIN_EN
  req_id_e           last_grant_q, last_grant_d;

  // Remember who won the most recent accept.
  always_comb begin
    if (accept_s) begin
      last_grant_d = winner_s;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Last-grant register; D after reset so the first tie goes to I.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q <= REQ_D;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign last_grant_s = last_grant_q;
`else
  // Claiming I won last makes the grant unit hand every tie to D.
  assign last_grant_s = REQ_I;
`endif

  mem_arb_grant u_grant (
    .i_valid    (i_req_valid),
    .d_valid    (d_req_valid),
    .last_grant (last_grant_s),
    .winner     (winner_s)
  );

  assign any_valid_s = i_req_valid | d_req_valid;
  // Gating with reset keeps the ready outputs low while reset is held.
  assign accept_s    = (state_q == IDLE) && any_valid_s && reset;
  // Timeout fires on the TIMEOUT-th RESP cycle; a real response wins.
  assign timeout_s   = (state_q == RESP) && !m_rsp_valid && (cnt_q == CNT_LAST);

  // Next-state and request-latch logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          owner_d = winner_s;
          state_d = REQ;
          if (winner_s == REQ_D) begin
            addr_d  = d_req_addr;
            wstrb_d = d_req_wstrb;
            wdata_d = d_req_wdata;
          end else begin
            addr_d  = i_req_addr;
            wstrb_d = 4'b0000;
            wdata_d = 32'h0000_0000;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (m_req_ready) begin
          state_d = RESP;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = REQ;
        end
      end
      RESP: begin
        if (m_rsp_valid) begin
          state_d = IDLE;
        end else if (timeout_s) begin
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        // The late response is swallowed here; no timeout applies.
        if (m_rsp_valid) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and latched request registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      owner_q <= REQ_D;
      addr_q  <= {ADDR_W{1'b0}};
      wstrb_q <= 4'b0000;
      wdata_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
    end
  end

  // Output decode; every output idles at zero.
  always_comb begin
    i_req_ready = 1'b0;
    d_req_ready = 1'b0;
    i_rsp_valid = 1'b0;
    d_rsp_valid = 1'b0;
    rsp_rdata   = 32'h0000_0000;
    rsp_err     = 1'b0;
    m_req_valid = 1'b0;
    m_req_addr  = {ADDR_W{1'b0}};
    m_req_wstrb = 4'b0000;
    m_req_wdata = 32'h0000_0000;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          i_req_ready = (winner_s == REQ_I);
          d_req_ready = (winner_s == REQ_D);
        end else begin
          i_req_ready = 1'b0;
          d_req_ready = 1'b0;
        end
      end
      REQ: begin
        m_req_valid = 1'b1;
        m_req_addr  = addr_q;
        m_req_wstrb = wstrb_q;
        m_req_wdata = wdata_q;
      end
      RESP: begin
        if (m_rsp_valid) begin
          i_rsp_valid = (owner_q == REQ_I);
          d_rsp_valid = (owner_q == REQ_D);
          rsp_rdata   = m_rsp_rdata;
          rsp_err     = 1'b0;
        end else if (timeout_s) begin
          i_rsp_valid = (owner_q == REQ_I);
          d_rsp_valid = (owner_q == REQ_D);
          rsp_rdata   = 32'h0000_0000;
          rsp_err     = 1'b1;
        end else begin
          rsp_err     = 1'b0;
        end
      end
      DRAIN: begin
        m_req_valid = 1'b0;
      end
      default: begin
        m_req_valid = 1'b0;
      end
    endcase
  end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter (TIMEOUT=4). A behavioural memory
// answers requests with a configurable ready stall and response latency;
// expected responses go into a scoreboard queue when stimulus is driven and
// are popped by a response monitor. Works with and without
// ARB_ROUND_ROBIN_EN defined.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  typedef struct packed {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req_valid, i_req_ready, i_rsp_valid;
  logic [31:0] i_req_addr;
  logic        d_req_valid, d_req_ready, d_rsp_valid;
  logic [31:0] d_req_addr;
  logic [3:0]  d_req_wstrb;
  logic [31:0] d_req_wdata;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        m_req_valid, m_req_ready;
  logic [31:0] m_req_addr;
  logic [3:0]  m_req_wstrb;
  logic [31:0] m_req_wdata;
  logic        m_rsp_valid;
  logic [31:0] m_rsp_rdata;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];
  bit   grant_log[$];   // 1 = D granted, 0 = I granted
  int   mem_hold = 0;   // cycles m_req_ready stays low after m_req_valid
  int   mem_lat  = 1;   // cycles from handshake to m_rsp_valid

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_wstrb(d_req_wstrb), .d_req_wdata(d_req_wdata), .d_rsp_valid(d_rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
    .m_req_wstrb(m_req_wstrb), .m_req_wdata(m_req_wdata),
    .m_rsp_valid(m_rsp_valid), .m_rsp_rdata(m_rsp_rdata)
  );

  // Memory contents: address 0x100 reads 0xDEADBEEF, others offset from it.
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return 32'hDEADBEEF + (a - 32'h0000_0100);
  endfunction

  task automatic mem_model();
    int          phase = 0;
    int          cnt   = 0;
    logic [31:0] cap   = 32'h0;
    forever begin
      @(posedge clk); #2;
      m_req_ready = 1'b0; m_rsp_valid = 1'b0; m_rsp_rdata = 32'h0;
      if (!rst_n) begin
        phase = 0;
      end else begin
        if (phase == 0 && m_req_valid) begin phase = 1; cnt = mem_hold; end
        if (phase == 1) begin
          if (cnt == 0) begin
            m_req_ready = 1'b1; cap = m_req_addr; phase = 2; cnt = mem_lat;
          end else cnt--;
        end else if (phase == 2) begin
          cnt--;
          if (cnt == 0) begin
            m_rsp_valid = 1'b1; m_rsp_rdata = mem_data(cap); phase = 0;
          end
        end
      end
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        n_checks++;
        if (i_rsp_valid || d_rsp_valid) begin
          if (sb.size() == 0) begin
            $display("FAIL rsp_unexpected: got i_rsp=%0b d_rsp=%0b rdata=%h err=%0b, expected no response",
                     i_rsp_valid, d_rsp_valid, rsp_rdata, rsp_err);
          end else begin
            e = sb.pop_front();
            if (i_rsp_valid !== !e.is_d || d_rsp_valid !== e.is_d ||
                rsp_rdata !== e.rdata || rsp_err !== e.err)
              $display("FAIL rsp_payload: got i_rsp=%0b d_rsp=%0b rdata=%h err=%0b, expected i_rsp=%0b d_rsp=%0b rdata=%h err=%0b",
                       i_rsp_valid, d_rsp_valid, rsp_rdata, rsp_err, !e.is_d, e.is_d, e.rdata, e.err);
            else n_pass++;
          end
        end else begin
          if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0)
            $display("FAIL rsp_idle_zero: got rdata=%h err=%0b, expected 0/0", rsp_rdata, rsp_err);
          else n_pass++;
        end
        if (i_req_ready || d_req_ready) begin
          n_checks++;
          if ((i_req_ready && d_req_ready) || (i_req_ready && !i_req_valid) ||
              (d_req_ready && !d_req_valid))
            $display("FAIL ready_onehot: got i_ready=%0b d_ready=%0b (i_valid=%0b d_valid=%0b), expected one ready for a valid requester",
                     i_req_ready, d_req_ready, i_req_valid, d_req_valid);
          else n_pass++;
          grant_log.push_back(d_req_ready);
        end
      end
    end
  endtask

  task automatic wait_sb_empty(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (sb.size() == 0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_req_valid = 1'b1; i_req_addr = 32'h10;
    d_req_valid = 1'b1; d_req_addr = 32'h20; d_req_wstrb = 4'hF; d_req_wdata = 32'h55;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({i_req_ready, d_req_ready, i_rsp_valid, d_rsp_valid, m_req_valid, rsp_err} !== 6'b0 ||
        rsp_rdata !== 32'h0 || m_req_addr !== 32'h0 || m_req_wstrb !== 4'h0 || m_req_wdata !== 32'h0)
      $display("FAIL reset_outputs: got ready=%b%b rsp=%b%b mreq=%b addr=%h, expected all zero",
               i_req_ready, d_req_ready, i_rsp_valid, d_rsp_valid, m_req_valid, m_req_addr);
    else n_pass++;
    @(posedge clk); #1;
    i_req_valid = 1'b0; d_req_valid = 1'b0; d_req_wstrb = 4'h0; d_req_wdata = 32'h0;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (m_req_valid !== 1'b0 || i_req_ready !== 1'b0 || d_req_ready !== 1'b0)
      $display("FAIL reset_release_idle: got mreq=%b ready=%b%b, expected 0", m_req_valid, i_req_ready, d_req_ready);
    else n_pass++;
  endtask

  task automatic test_single_read();
    bit ok;
    mem_hold = 0; mem_lat = 1;
    @(posedge clk); #1;
    i_req_valid = 1'b1; i_req_addr = 32'h100;
    sb.push_back('{is_d: 1'b0, rdata: 32'hDEADBEEF, err: 1'b0});
    sb.push_back('{is_d: 1'b0, rdata: 32'hDEADBEEF, err: 1'b0});
    @(negedge clk);
    n_checks++;
    if (i_req_ready !== 1'b1 || d_req_ready !== 1'b0 || m_req_valid !== 1'b0)
      $display("FAIL single_accept: got i_ready=%b d_ready=%b mreq=%b, expected 1/0/0", i_req_ready, d_req_ready, m_req_valid);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (m_req_valid !== 1'b1 || m_req_addr !== 32'h100 || m_req_wstrb !== 4'h0 ||
        m_req_wdata !== 32'h0 || i_req_ready !== 1'b0)
      $display("FAIL single_mreq: got mreq=%b addr=%h wstrb=%h i_ready=%b, expected 1/00000100/0/0",
               m_req_valid, m_req_addr, m_req_wstrb, i_req_ready);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (i_rsp_valid !== 1'b1 || d_rsp_valid !== 1'b0 || rsp_rdata !== 32'hDEADBEEF ||
        rsp_err !== 1'b0 || i_req_ready !== 1'b0)
      $display("FAIL single_rsp: got i_rsp=%b d_rsp=%b rdata=%h err=%b i_ready=%b, expected 1/0/deadbeef/0/0",
               i_rsp_valid, d_rsp_valid, rsp_rdata, rsp_err, i_req_ready);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (i_req_ready !== 1'b1)
      $display("FAIL single_reaccept: got i_ready=%b at N+3, expected 1", i_req_ready);
    else n_pass++;
    @(posedge clk); #1;
    i_req_valid = 1'b0; i_req_addr = 32'h0;
    wait_sb_empty(20, ok);
    n_checks++;
    if (!ok) $display("FAIL single_drain: got %0d pending responses, expected 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit exp_order[$];
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_order = '{1'b1, 1'b1, 1'b1};
`endif
    mem_hold = 0; mem_lat = 1;
    grant_log.delete();
    @(posedge clk); #1;
    i_req_valid = 1'b1; i_req_addr = 32'h200;
    d_req_valid = 1'b1; d_req_addr = 32'h300; d_req_wstrb = 4'h0; d_req_wdata = 32'h0;
    foreach (exp_order[k])
      sb.push_back('{is_d: exp_order[k], rdata: mem_data(exp_order[k] ? 32'h300 : 32'h200), err: 1'b0});
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (grant_log.size() >= exp_order.size()) break;
    end
    @(posedge clk); #1;
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    n_checks++;
    if (grant_log.size() != exp_order.size())
      $display("FAIL b2b_grant_count: got %0d grants, expected %0d", grant_log.size(), exp_order.size());
    else n_pass++;
    foreach (exp_order[k]) begin
      logic got;
      got = (k < grant_log.size()) ? grant_log[k] : 1'bx;
      n_checks++;
      if (got !== exp_order[k])
        $display("FAIL b2b_grant_%0d: got winner d=%b, expected d=%b", k, got, exp_order[k]);
      else n_pass++;
    end
    wait_sb_empty(30, ok);
    n_checks++;
    if (!ok) $display("FAIL b2b_drain: got %0d pending responses, expected 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_write_stall();
    bit ok;
    mem_hold = 5; mem_lat = 1;
    @(posedge clk); #1;
    d_req_valid = 1'b1; d_req_addr = 32'h400; d_req_wstrb = 4'b0011; d_req_wdata = 32'h12345678;
    sb.push_back('{is_d: 1'b1, rdata: mem_data(32'h400), err: 1'b0});
    @(negedge clk);
    n_checks++;
    if (d_req_ready !== 1'b1) $display("FAIL wr_accept: got d_ready=%b, expected 1", d_req_ready);
    else n_pass++;
    @(posedge clk); #1;
    d_req_valid = 1'b0; d_req_addr = 32'h0; d_req_wstrb = 4'h0; d_req_wdata = 32'h0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_checks++;
      if (m_req_valid !== 1'b1 || m_req_addr !== 32'h400 || m_req_wstrb !== 4'b0011 ||
          m_req_wdata !== 32'h12345678 || m_req_ready !== (k == 5))
        $display("FAIL wr_stall_%0d: got v=%b addr=%h wstrb=%b wdata=%h ready=%b, expected 1/00000400/0011/12345678/%0b",
                 k, m_req_valid, m_req_addr, m_req_wstrb, m_req_wdata, m_req_ready, (k == 5));
      else n_pass++;
    end
    wait_sb_empty(20, ok);
    n_checks++;
    if (!ok) $display("FAIL wr_drain: got %0d pending responses, expected 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_timeout();
    bit ok;
    mem_hold = 0; mem_lat = 6;
    @(posedge clk); #1;
    i_req_valid = 1'b1; i_req_addr = 32'h500;
    sb.push_back('{is_d: 1'b0, rdata: 32'h0, err: 1'b1});
    @(negedge clk);
    n_checks++;
    if (i_req_ready !== 1'b1) $display("FAIL to_accept: got i_ready=%b, expected 1", i_req_ready);
    else n_pass++;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (i_rsp_valid !== 1'b0) $display("FAIL to_not_early: got i_rsp=%b on 3rd RESP cycle, expected 0", i_rsp_valid);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (i_rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || d_rsp_valid !== 1'b0)
      $display("FAIL to_err: got i_rsp=%b err=%b rdata=%h d_rsp=%b, expected 1/1/0/0",
               i_rsp_valid, rsp_err, rsp_rdata, d_rsp_valid);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++;
    if (m_rsp_valid !== 1'b1 || i_rsp_valid !== 1'b0 || d_rsp_valid !== 1'b0)
      $display("FAIL to_drain_discard: got m_rsp=%b i_rsp=%b d_rsp=%b, expected 1/0/0",
               m_rsp_valid, i_rsp_valid, d_rsp_valid);
    else n_pass++;
    mem_lat = 1;
    @(posedge clk); #1;
    d_req_valid = 1'b1; d_req_addr = 32'h700; d_req_wstrb = 4'h0;
    sb.push_back('{is_d: 1'b1, rdata: mem_data(32'h700), err: 1'b0});
    @(negedge clk);
    n_checks++;
    if (d_req_ready !== 1'b1) $display("FAIL to_next_accept: got d_ready=%b, expected 1", d_req_ready);
    else n_pass++;
    @(posedge clk); #1;
    d_req_valid = 1'b0;
    wait_sb_empty(20, ok);
    n_checks++;
    if (!ok) $display("FAIL to_drain: got %0d pending responses, expected 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    mem_hold = 0; mem_lat = 4;
    @(posedge clk); #1;
    d_req_valid = 1'b1; d_req_addr = 32'h600; d_req_wstrb = 4'h0;
    @(negedge clk);
    n_checks++;
    if (d_req_ready !== 1'b1) $display("FAIL rm_accept: got d_ready=%b, expected 1", d_req_ready);
    else n_pass++;
    @(posedge clk); #1;
    d_req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; i_req_valid = 1'b1; i_req_addr = 32'h900;
    #2;
    n_checks++;
    if ({i_req_ready, d_req_ready, i_rsp_valid, d_rsp_valid, m_req_valid, rsp_err} !== 6'b0 ||
        rsp_rdata !== 32'h0 || m_req_addr !== 32'h0)
      $display("FAIL rm_outputs_zero: got ready=%b%b rsp=%b%b mreq=%b err=%b, expected all zero",
               i_req_ready, d_req_ready, i_rsp_valid, d_rsp_valid, m_req_valid, rsp_err);
    else n_pass++;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    i_req_valid = 1'b0; rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (m_req_valid !== 1'b0 || sb.size() != 0)
      $display("FAIL rm_quiet: got mreq=%b pending=%0d after release, expected 0/0", m_req_valid, sb.size());
    else n_pass++;
    mem_lat = 1;
    @(posedge clk); #1;
    i_req_valid = 1'b1; i_req_addr = 32'h800;
    sb.push_back('{is_d: 1'b0, rdata: mem_data(32'h800), err: 1'b0});
    @(negedge clk);
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    wait_sb_empty(20, ok);
    n_checks++;
    if (!ok) $display("FAIL rm_next_txn: got %0d pending responses, expected 0", sb.size());
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    i_req_valid = 1'b0; i_req_addr = 32'h0;
    d_req_valid = 1'b0; d_req_addr = 32'h0; d_req_wstrb = 4'h0; d_req_wdata = 32'h0;
    m_req_ready = 1'b0; m_rsp_valid = 1'b0; m_rsp_rdata = 32'h0;
    fork
      mem_model();
      monitor();
    join_none
    test_reset();
    test_single_read();
    test_back_to_back();
    test_write_stall();
    test_timeout();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mem_arbiter
